// File: rtl/uart_rx_pkg.sv
// Shared types and sample points for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] SAMP_MID = 4'd7;
  localparam logic [3:0] SAMP_END = 4'd15;

endpackage

// File: rtl/uart_rx_sync.sv
// Synchroniser chain for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_i,
  output logic rx_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rx_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start detect, mid-bit sampling on the 16x tick,
// and a one-deep output holding register with parity/framing/overflow status.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       rx_idle
);

  logic       rx_s;
  state_t     state_q, state_d;
  logic [3:0] samp_cnt_q, samp_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_err_q, par_err_d;
  logic       armed_q, armed_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_rdy_q, rx_rdy_d;
  logic       parity_err_q, parity_err_d;
  logic       framing_err_q, framing_err_d;
  logic       overflow_q, overflow_d;
  logic       rx_idle_q, rx_idle_d;
  logic       frame_done, frame_fe;
  logic [2:0] last_bit;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .rx_i   (rx),
    .rx_s_o (rx_s)
  );

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    armed_d    = armed_q;
    frame_done = 1'b0;
    frame_fe   = 1'b0;
    last_bit   = bit8 ? 3'd7 : 3'd6;

    if (baud_clock) begin
      if (rx_s) armed_d = 1'b1;
      samp_cnt_d = samp_cnt_q + 4'd1;
      unique case (state_q)
        IDLE: begin
          if (!rx_s && armed_q) begin
            state_d    = START;
            samp_cnt_d = '0;
          end
        end
        START: begin
          if (samp_cnt_q == SAMP_MID) begin
            if (!rx_s) begin
              state_d    = DATA;
              samp_cnt_d = '0;
              bit_cnt_d  = '0;
              shift_d    = '0;
              par_err_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          // Bits land at their final index, so bit 7 stays 0 in 7-bit mode.
          if (samp_cnt_q == SAMP_END) begin
            shift_d[bit_cnt_q] = rx_s;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == last_bit) state_d = parity_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (samp_cnt_q == SAMP_END) begin
            par_err_d = ((^shift_q) ^ rx_s) != odd_n_even;
            state_d   = STOP;
          end
        end
        STOP: begin
          if (samp_cnt_q == SAMP_END) begin
            frame_done = 1'b1;
            frame_fe   = ~rx_s;
            if (!rx_s) armed_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_byte_d     = rx_byte_q;
    rx_rdy_d      = rx_rdy_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;
    rx_idle_d     = rx_idle_q;

    if (read_rx_byte) begin
      rx_rdy_d   = 1'b0;
      overflow_d = 1'b0;
    end
    // A read in the completion cycle frees the register for the new frame.
    if (frame_done) begin
      if (!rx_rdy_q || read_rx_byte) begin
        rx_byte_d     = shift_q;
        parity_err_d  = par_err_q;
        framing_err_d = frame_fe;
        rx_rdy_d      = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (state_d != IDLE)       rx_idle_d = 1'b0;
    else if (armed_d)          rx_idle_d = 1'b1;
    else if (state_q != IDLE)  rx_idle_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      samp_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      armed_q       <= 1'b0;
      rx_byte_q     <= '0;
      rx_rdy_q      <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
      rx_idle_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      samp_cnt_q    <= samp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_err_q     <= par_err_d;
      armed_q       <= armed_d;
      rx_byte_q     <= rx_byte_d;
      rx_rdy_q      <= rx_rdy_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
      rx_idle_q     <= rx_idle_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_rdy      = rx_rdy_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;
  assign rx_idle     = rx_idle_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: serial frames built bit by bit, outputs checked against a frame-level model.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_clock = 1'b0;
  logic       rx = 1'b1;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       read_rx_byte = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_rdy, parity_err, framing_err, overflow, rx_idle;

  int total = 0;
  int bad = 0;

  logic       e_rdy = 1'b0, e_ovf = 1'b0, e_pe = 1'b0, e_fe = 1'b0;
  logic [7:0] e_byte = 8'h00;
  logic [1:0] bdiv = 2'd0;

  uart_rx_core #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_clock  (baud_clock),
    .rx          (rx),
    .bit8        (bit8),
    .parity_en   (parity_en),
    .odd_n_even  (odd_n_even),
    .read_rx_byte(read_rx_byte),
    .rx_byte     (rx_byte),
    .rx_rdy      (rx_rdy),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overflow    (overflow),
    .rx_idle     (rx_idle)
  );

  always #5 clk = ~clk;

  // 16x tick: one clk wide, every fourth clk.
  always @(negedge clk) begin
    bdiv = bdiv + 2'd1;
    baud_clock = (bdiv == 2'd0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * 64) step();
  endtask

  // Start is driven just before a tick edge so completion lands at a known clk.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input bit rd_at_done, output int rise_k);
    logic [11:0] fr;
    int nb, nd, k;
    logic prev;
    do step(); while (baud_clock !== 1'b1);
    fr = '0;
    nd = bit8 ? 8 : 7;
    fr[0] = 1'b0;
    for (int i = 0; i < nd; i++) fr[1 + i] = d[i];
    nb = 1 + nd;
    if (parity_en) begin fr[nb] = pbit; nb++; end
    fr[nb] = stop; nb++;
    rise_k = -1;
    prev = rx_rdy;
    k = 0;
    for (int b = 0; b < nb; b++) begin
      rx = fr[b];
      for (int i = 0; i < 64; i++) begin
        read_rx_byte = rd_at_done && (b == nb - 1) && (i == 36);
        step();
        k++;
        if (rx_rdy === 1'b1 && prev !== 1'b1 && rise_k < 0) rise_k = k;
        prev = rx_rdy;
      end
    end
    read_rx_byte = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic pbit, input logic stop, input bit rd);
    logic [7:0] m;
    int ones;
    m = bit8 ? d : {1'b0, d[6:0]};
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(m[i]);
    if (rd) begin e_rdy = 1'b0; e_ovf = 1'b0; end
    if (!e_rdy) begin
      e_byte = m;
      e_pe   = parity_en ? (((ones + int'(pbit)) % 2) != int'(odd_n_even)) : 1'b0;
      e_fe   = ~stop;
      e_rdy  = 1'b1;
    end else begin
      e_ovf = 1'b1;
    end
  endtask

  task automatic xfer(input logic [7:0] d, input logic pbit, input logic stop,
                      input bit rd, output int rise_k);
    send_frame(d, pbit, stop, rd, rise_k);
    model_frame(d, pbit, stop, rd);
  endtask

  task automatic do_read();
    read_rx_byte = 1'b1;
    step();
    read_rx_byte = 1'b0;
    e_rdy = 1'b0;
    e_ovf = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", {rx_rdy, overflow, parity_err, framing_err, rx_byte}, 12'h000);
    end
    total++;
    if (rx_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", rx_idle); end
  endtask

  task automatic test_8n1();
    int rk;
    bit8 = 1'b1; parity_en = 1'b0;
    idle_bits(1);
    xfer(8'hA5, 1'b0, 1'b1, 1'b0, rk);
    idle_bits(1);
    total++;
    if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== {e_rdy, e_ovf, e_pe, e_fe, e_byte}) begin
      bad++;
      $display("FAIL 8n1_A5 got=%h exp=%h", {rx_rdy, overflow, parity_err, framing_err, rx_byte}, {e_rdy, e_ovf, e_pe, e_fe, e_byte});
    end
    total++;
    if (rk < 611 || rk > 615) begin bad++; $display("FAIL 8n1_latency got=%0d exp=611..615 clk", rk); end
    do_read();
  endtask

  task automatic test_parity();
    int rk;
    bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b0;
    idle_bits(1);
    for (int p = 0; p < 2; p++) begin
      xfer(8'h37, p[0], 1'b1, 1'b0, rk);
      idle_bits(1);
      total++;
      if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== {e_rdy, e_ovf, e_pe, e_fe, e_byte}) begin
        bad++;
        $display("FAIL 8e1_37_p%0d got=%h exp=%h", p, {rx_rdy, overflow, parity_err, framing_err, rx_byte}, {e_rdy, e_ovf, e_pe, e_fe, e_byte});
      end
      do_read();
    end
    parity_en = 1'b0;
  endtask

  task automatic test_break();
    int rk;
    logic idle_seen;
    bit8 = 1'b1; parity_en = 1'b0;
    idle_bits(1);
    xfer(8'h55, 1'b0, 1'b0, 1'b0, rk);
    idle_seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 12 * 64; i++) begin
      step();
      if (rx_idle !== 1'b0) idle_seen = 1'b1;
    end
    total++;
    if (idle_seen !== 1'b0) begin bad++; $display("FAIL break_idle_low got=1 exp=0"); end
    total++;
    if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== {e_rdy, e_ovf, e_pe, e_fe, e_byte}) begin
      bad++;
      $display("FAIL break_frame got=%h exp=%h", {rx_rdy, overflow, parity_err, framing_err, rx_byte}, {e_rdy, e_ovf, e_pe, e_fe, e_byte});
    end
    idle_bits(1);
    total++;
    if (rx_idle !== 1'b1) begin bad++; $display("FAIL break_rearm got=%b exp=1", rx_idle); end
    do_read();
  endtask

  task automatic test_glitch();
    int rk;
    do step(); while (baud_clock !== 1'b1);
    rx = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 17) rx = 1'b1;
      step();
      if (k == 20) begin
        total++;
        if (rx_idle !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b exp=0", rx_idle); end
      end
      if (k == 45) begin
        total++;
        if ({rx_idle, rx_rdy} !== 2'b10) begin bad++; $display("FAIL glitch_reject got=%b exp=10", {rx_idle, rx_rdy}); end
      end
    end
    xfer(8'h3C, 1'b0, 1'b1, 1'b0, rk);
    idle_bits(1);
    total++;
    if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== {e_rdy, e_ovf, e_pe, e_fe, e_byte}) begin
      bad++;
      $display("FAIL glitch_then_3C got=%h exp=%h", {rx_rdy, overflow, parity_err, framing_err, rx_byte}, {e_rdy, e_ovf, e_pe, e_fe, e_byte});
    end
    do_read();
  endtask

  task automatic test_back_to_back();
    int rk;
    bit8 = 1'b1; parity_en = 1'b0;
    idle_bits(1);
    xfer(8'h11, 1'b0, 1'b1, 1'b0, rk);
    idle_bits(1);
    xfer(8'h22, 1'b0, 1'b1, 1'b0, rk);
    idle_bits(1);
    total++;
    if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== {e_rdy, e_ovf, e_pe, e_fe, e_byte}) begin
      bad++;
      $display("FAIL overflow_hold got=%h exp=%h", {rx_rdy, overflow, parity_err, framing_err, rx_byte}, {e_rdy, e_ovf, e_pe, e_fe, e_byte});
    end
    do_read();
    total++;
    if ({rx_rdy, overflow} !== 2'b00) begin bad++; $display("FAIL overflow_read got=%b exp=00", {rx_rdy, overflow}); end
    xfer(8'h11, 1'b0, 1'b1, 1'b0, rk);
    idle_bits(1);
    xfer(8'h22, 1'b0, 1'b1, 1'b1, rk);
    idle_bits(1);
    total++;
    if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== {e_rdy, e_ovf, e_pe, e_fe, e_byte}) begin
      bad++;
      $display("FAIL read_at_done got=%h exp=%h", {rx_rdy, overflow, parity_err, framing_err, rx_byte}, {e_rdy, e_ovf, e_pe, e_fe, e_byte});
    end
    do_read();
  endtask

  task automatic test_reset_abort();
    int rk;
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
    idle_bits(1);
    xfer(8'h41, 1'b1, 1'b1, 1'b0, rk);
    idle_bits(1);
    total++;
    if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== {e_rdy, e_ovf, e_pe, e_fe, e_byte}) begin
      bad++;
      $display("FAIL 7o1_41 got=%h exp=%h", {rx_rdy, overflow, parity_err, framing_err, rx_byte}, {e_rdy, e_ovf, e_pe, e_fe, e_byte});
    end
    // Next frame: start, data bits 0..2, then reset in the middle of bit 3.
    do step(); while (baud_clock !== 1'b1);
    rx = 1'b0;
    repeat (64) step();
    for (int b = 0; b < 3; b++) begin
      rx = b[0];
      repeat (64) step();
    end
    rx = 1'b1;
    repeat (32) step();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    e_rdy = 1'b0; e_ovf = 1'b0; e_pe = 1'b0; e_fe = 1'b0; e_byte = 8'h00;
    total++;
    if ({rx_idle, rx_rdy, overflow, parity_err, framing_err, rx_byte} !== 13'h1000) begin
      bad++;
      $display("FAIL abort_reset got=%h exp=%h", {rx_idle, rx_rdy, overflow, parity_err, framing_err, rx_byte}, 13'h1000);
    end
    bit8 = 1'b1; parity_en = 1'b0;
    idle_bits(2);
    xfer(8'h0F, 1'b0, 1'b1, 1'b0, rk);
    idle_bits(1);
    total++;
    if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== {e_rdy, e_ovf, e_pe, e_fe, e_byte}) begin
      bad++;
      $display("FAIL after_reset_0F got=%h exp=%h", {rx_rdy, overflow, parity_err, framing_err, rx_byte}, {e_rdy, e_ovf, e_pe, e_fe, e_byte});
    end
    do_read();
  endtask

  task automatic test_random();
    int rk;
    logic [7:0] d;
    logic pb, sb;
    for (int n = 0; n < 12; n++) begin
      bit8       = $urandom_range(0, 1) == 1;
      parity_en  = $urandom_range(0, 1) == 1;
      odd_n_even = $urandom_range(0, 1) == 1;
      d  = 8'($urandom);
      pb = $urandom_range(0, 1) == 1;
      sb = $urandom_range(0, 3) != 0;
      idle_bits(1);
      xfer(d, pb, sb, 1'b0, rk);
      idle_bits(1);
      total++;
      if ({rx_rdy, overflow, parity_err, framing_err, rx_byte} !== {e_rdy, e_ovf, e_pe, e_fe, e_byte}) begin
        bad++;
        $display("FAIL rand%0d d=%h b8=%b pen=%b odd=%b p=%b s=%b got=%h exp=%h", n, d, bit8, parity_en,
                 odd_n_even, pb, sb, {rx_rdy, overflow, parity_err, framing_err, rx_byte},
                 {e_rdy, e_ovf, e_pe, e_fe, e_byte});
      end
      do_read();
      total++;
      if (rx_rdy !== 1'b0) begin bad++; $display("FAIL rand%0d_read got=%b exp=0", n, rx_rdy); end
    end
  endtask

  initial begin
    repeat (5) step();
    reset_n = 1'b1;
    step();
    test_reset();
    test_8n1();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
